// File: rtl/pixel_sequencer_gen.sv
// Pixel sequencer: word FIFO from fetch, fine-scroll load, hires/multicolor decode,
// border override and sticky underflow, two-stage pipeline on the 4x dot clock.
module pixel_sequencer_gen #(
    parameter int DOTS       = 8,
    parameter int WORD_BITS  = 8,
    parameter int COLOR_BITS = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      i_clk_dot4x,
    input  logic                      i_rst,
    input  logic                      i_dot_tick,
    input  logic                      i_line_start,
    input  logic                      i_line_active,
    input  logic [1:0]                i_mode,
    input  logic [$clog2(DOTS)-1:0]   i_xscroll,
    input  logic                      i_border,
    input  logic [COLOR_BITS-1:0]     i_ec,
    input  logic [COLOR_BITS-1:0]     i_bg0,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [WORD_BITS-1:0]      i_in_pixels,
    input  logic [3*COLOR_BITS-1:0]   i_in_attr,
    output logic [COLOR_BITS-1:0]     o_pixel_color,
    output logic                      o_pixel_valid,
    output logic                      o_is_background,
    output logic                      o_underflow,
    input  logic                      i_clr_underflow
);
    localparam int XW = $clog2(DOTS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int AB = 3 * COLOR_BITS;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [WORD_BITS-1:0]  r_fifo_pix  [FIFO_DEPTH];
    logic [AB-1:0]         r_fifo_attr [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  w_full, w_empty, w_push, w_pop;

    logic [XW-1:0]         r_dot_cnt, r_xscroll_l, w_d, w_xs;
    logic [WORD_BITS-1:0]  r_shifter, w_sh_now, w_sh_next;
    logic [AB-1:0]         r_attr_l, w_attr_now;
    logic                  r_mc_phase, w_phase_now, w_load;
    logic [1:0]            w_code;

    logic                  r_a_valid, r_a_border;
    logic [1:0]            r_a_code, r_a_mode;
    logic [AB-1:0]         r_a_attr;
    logic                  r_pix_valid, r_is_bg, r_underflow;
    logic [COLOR_BITS-1:0] r_pix_color, w_color, w_fg, w_c1, w_c2;
    logic                  w_is_bg;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign o_in_ready = !w_full;
    assign w_push     = i_in_valid && !w_full;

    assign w_d    = i_line_start ? '0 : r_dot_cnt;
    // On dot 0 the incoming scroll value already governs this word's load point.
    assign w_xs   = (w_d == '0) ? i_xscroll : r_xscroll_l;
    assign w_load = i_dot_tick && (w_d == w_xs);
    assign w_pop  = w_load && i_line_active && !w_empty;

    always_comb begin
        w_sh_now    = r_shifter;
        w_attr_now  = r_attr_l;
        w_phase_now = r_mc_phase;
        if (w_load) begin
            w_phase_now = 1'b0;
            w_sh_now    = w_pop ? r_fifo_pix[r_rd_ptr] : '0;
            if (w_pop) w_attr_now = r_fifo_attr[r_rd_ptr];
        end
        if (i_mode == 2'd1) begin
            w_code    = w_sh_now[WORD_BITS-1 -: 2];
            w_sh_next = w_phase_now ? (w_sh_now << 2) : w_sh_now;
        end else begin
            w_code    = {2{w_sh_now[WORD_BITS-1]}};
            w_sh_next = w_sh_now << 1;
        end
    end

    assign w_fg = r_a_attr[AB-1 -: COLOR_BITS];
    assign w_c1 = r_a_attr[2*COLOR_BITS-1 -: COLOR_BITS];
    assign w_c2 = r_a_attr[COLOR_BITS-1:0];

    always_comb begin
        w_color = '0;
        w_is_bg = 1'b1;
        case (r_a_mode)
            2'd0: begin
                w_color = (r_a_code == 2'b11) ? w_fg : i_bg0;
                w_is_bg = !r_a_code[1];
            end
            2'd1: begin
                case (r_a_code)
                    2'b00:   w_color = i_bg0;
                    2'b01:   w_color = w_c1;
                    2'b10:   w_color = w_c2;
                    default: w_color = w_fg;
                endcase
                w_is_bg = !r_a_code[1];
            end
            default: ;
        endcase
        if (r_a_border) w_color = i_ec;
    end

    always_ff @(posedge i_clk_dot4x) begin
        if (w_push) begin
            r_fifo_pix[r_wr_ptr]  <= i_in_pixels;
            r_fifo_attr[r_wr_ptr] <= i_in_attr;
        end
    end

    always_ff @(posedge i_clk_dot4x) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_dot_cnt   <= '0;
            r_xscroll_l <= '0;
            r_shifter   <= '0;
            r_attr_l    <= '0;
            r_mc_phase  <= 1'b0;
            r_a_valid   <= 1'b0;
            r_a_border  <= 1'b0;
            r_a_code    <= '0;
            r_a_mode    <= '0;
            r_a_attr    <= '0;
            r_pix_valid <= 1'b0;
            r_pix_color <= '0;
            r_is_bg     <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (i_dot_tick) begin
                r_dot_cnt  <= w_d + 1'b1;
                if (w_d == '0) r_xscroll_l <= i_xscroll;
                r_shifter  <= w_sh_next;
                r_attr_l   <= w_attr_now;
                r_mc_phase <= !w_phase_now;
                r_a_code   <= w_code;
                r_a_mode   <= i_mode;
                r_a_border <= i_border;
                r_a_attr   <= w_attr_now;
            end
            r_a_valid   <= i_dot_tick;
            r_pix_valid <= r_a_valid;
            if (r_a_valid) begin
                r_pix_color <= w_color;
                r_is_bg     <= w_is_bg;
            end
            if (w_load && i_line_active && w_empty) r_underflow <= 1'b1;
            else if (i_clr_underflow)              r_underflow <= 1'b0;
        end
    end

    assign o_pixel_color   = r_pix_color;
    assign o_pixel_valid   = r_pix_valid;
    assign o_is_background = r_is_bg;
    assign o_underflow     = r_underflow;
endmodule

// File: tb/tb_pixel_sequencer_gen.sv
// Bench for pixel_sequencer_gen: word-index reference model plus literal pixel sequences.
module tb_pixel_sequencer_gen;
    localparam int DOTS  = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0, rst = 1'b1, dot_tick = 1'b0, line_start = 1'b0, line_active = 1'b0;
    logic border = 1'b0, in_valid = 1'b0, clr_uf = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [2:0]  xscroll = 3'd0;
    logic [3:0]  ec = 4'd0, bg0 = 4'd0;
    logic [7:0]  in_pixels = 8'd0;
    logic [11:0] in_attr = 12'd0;
    logic        in_ready, pixel_valid, is_bg, underflow;
    logic [3:0]  pixel_color;

    always #5 clk = ~clk;

    pixel_sequencer_gen dut (
        .i_clk_dot4x(clk), .i_rst(rst), .i_dot_tick(dot_tick), .i_line_start(line_start),
        .i_line_active(line_active), .i_mode(mode), .i_xscroll(xscroll), .i_border(border),
        .i_ec(ec), .i_bg0(bg0), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_pixels(in_pixels), .i_in_attr(in_attr), .o_pixel_color(pixel_color),
        .o_pixel_valid(pixel_valid), .o_is_background(is_bg), .o_underflow(underflow),
        .i_clr_underflow(clr_uf)
    );

    typedef struct { logic [7:0] pix; logic [11:0] attr; } word_t;
    typedef struct { int due; logic [3:0] color; logic bg; } exp_t;

    word_t mq[$];
    exp_t  eq[$];
    int    cyc = 0, m_cnt = 0, m_xs = 0, m_k = 2*DOTS;
    logic [7:0]  m_word = 8'd0;
    logic [11:0] m_attr = 12'd0;
    logic m_uf = 1'b0, m_valid = 1'b0, m_bg = 1'b1, m_ready = 1'b1;
    logic [3:0] m_color = 4'd0;

    int n_cmp = 0, n_bad = 0;
    logic [3:0] log_c[$];
    logic       log_b[$];
    int         lit[$];
    int         litb[$];

    // Colour of the k-th dot after a word load: bits are consumed MSB first,
    // one per dot in hires, one pair per two dots in multicolor.
    function automatic logic [4:0] pixel_of(input logic [7:0] w, input int k, input logic [1:0] md,
                                            input logic [11:0] a, input logic brd,
                                            input logic [3:0] bgc, input logic [3:0] ecc);
        logic [1:0] code;
        logic [3:0] col;
        logic       bgf;
        int         p;
        code = 2'b00;
        p = k / 2;
        if (md == 2'd1) begin
            if (p < DOTS/2) code = {w[DOTS-1-2*p], w[DOTS-2-2*p]};
        end else if (k < DOTS) begin
            code = {2{w[DOTS-1-k]}};
        end
        col = 4'd0;
        if (md == 2'd0) col = (code == 2'b11) ? a[11:8] : bgc;
        else if (md == 2'd1) begin
            case (code)
                2'b00:   col = bgc;
                2'b01:   col = a[7:4];
                2'b10:   col = a[3:0];
                default: col = a[11:8];
            endcase
        end
        bgf = (md >= 2'd2) ? 1'b1 : !code[1];
        if (brd) col = ecc;
        return {col, bgf};
    endfunction

    always @(posedge clk) begin : model
        logic  ready_before, uf_set;
        logic [4:0] r;
        int    d;
        exp_t  e;
        word_t w;
        if (rst) begin
            mq.delete(); eq.delete();
            m_cnt = 0; m_xs = 0; m_k = 2*DOTS; m_word = 8'd0; m_attr = 12'd0;
            m_uf = 1'b0; m_valid = 1'b0; m_color = 4'd0; m_bg = 1'b1; m_ready = 1'b1;
        end else begin
            m_valid = 1'b0;
            if (eq.size() > 0 && eq[0].due == cyc) begin
                e = eq.pop_front();
                m_valid = 1'b1; m_color = e.color; m_bg = e.bg;
            end
            ready_before = mq.size() < DEPTH;
            uf_set = 1'b0;
            if (dot_tick) begin
                d = line_start ? 0 : m_cnt;
                m_cnt = (d + 1) % DOTS;
                if (d == 0) m_xs = int'(xscroll);
                if (d == m_xs) begin
                    m_k = 0;
                    if (line_active && mq.size() > 0) begin
                        w = mq.pop_front(); m_word = w.pix; m_attr = w.attr;
                    end else begin
                        m_word = 8'd0;
                        if (line_active) uf_set = 1'b1;
                    end
                end else if (m_k < 2*DOTS) m_k++;
                r = pixel_of(m_word, m_k, mode, m_attr, border, bg0, ec);
                e.due = cyc + 1; e.color = r[4:1]; e.bg = r[0];
                eq.push_back(e);
            end
            if (in_valid && ready_before) begin
                w.pix = in_pixels; w.attr = in_attr; mq.push_back(w);
            end
            if (uf_set) m_uf = 1'b1;
            else if (clr_uf) m_uf = 1'b0;
            m_ready = mq.size() < DEPTH;
        end
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("pixel_valid", pixel_valid, m_valid);
        check("pixel_color", pixel_color, m_color);
        check("is_background", is_bg, m_bg);
        check("in_ready", in_ready, m_ready);
        check("underflow", underflow, m_uf);
        if (pixel_valid) begin
            log_c.push_back(pixel_color);
            log_b.push_back(is_bg);
        end
    endtask

    task automatic tick(input logic ls, input logic brd);
        dot_tick = 1'b1; line_start = ls; border = brd;
        step();
        dot_tick = 1'b0; line_start = 1'b0; border = 1'b0;
        repeat (3) step();
    endtask

    task automatic line(input int brd_dot);
        for (int i = 0; i < DOTS; i++) tick(i == 0, i == brd_dot);
    endtask

    task automatic push(input logic [7:0] p, input logic [11:0] a);
        in_valid = 1'b1; in_pixels = p; in_attr = a;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    task automatic check_log(input string name, input int base, input logic chk_bg);
        if (log_c.size() < base + lit.size()) begin
            check({name, "_count"}, log_c.size() - base, lit.size());
        end else begin
            for (int i = 0; i < lit.size(); i++) begin
                check(name, log_c[base+i], lit[i]);
                if (chk_bg) check({name, "_bg"}, log_b[base+i], litb[i]);
            end
        end
    endtask

    initial begin
        int base;
        do_reset();
        check("rst_ready", in_ready, 1);
        check("rst_valid", pixel_valid, 0);
        check("rst_bg", is_bg, 1);
        check("rst_uf", underflow, 0);
        check("rst_color", pixel_color, 0);

        // hires, no scroll
        bg0 = 4'd6; mode = 2'd0; xscroll = 3'd0; line_active = 1'b1;
        push(8'hA5, {4'd1, 4'd2, 4'd3});
        base = log_c.size();
        line(-1);
        lit = '{1, 6, 1, 6, 6, 1, 6, 1};
        check_log("hires", base, 1'b0);

        // multicolor
        do_reset();
        bg0 = 4'd0; mode = 2'd1;
        push(8'h1B, {4'd7, 4'd2, 4'd5});
        base = log_c.size();
        line(-1);
        lit  = '{0, 0, 2, 2, 5, 5, 7, 7};
        litb = '{1, 1, 1, 1, 0, 0, 0, 0};
        check_log("multicolor", base, 1'b1);

        // fine scroll, mid-word change deferred to next line
        do_reset();
        mode = 2'd0; bg0 = 4'd0; xscroll = 3'd3;
        push(8'hFF, {4'd1, 4'd0, 4'd0});
        push(8'h00, {4'd1, 4'd0, 4'd0});
        base = log_c.size();
        for (int i = 0; i < DOTS; i++) begin
            if (i == 5) xscroll = 3'd6;
            tick(i == 0, 1'b0);
        end
        line(-1);
        lit = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        check_log("scroll", base, 1'b0);

        // FIFO full, pop while full, drain and underflow
        do_reset();
        bg0 = 4'd9; xscroll = 3'd0; in_attr = {4'd1, 4'd0, 4'd0};
        in_valid = 1'b1;
        in_pixels = 8'h80; step();
        in_pixels = 8'h40; step();
        in_pixels = 8'h20; step();
        in_pixels = 8'h10; step();
        check("full_ready", in_ready, 0);
        in_pixels = 8'hFF; dot_tick = 1'b1; line_start = 1'b1;
        step();
        in_valid = 1'b0; dot_tick = 1'b0; line_start = 1'b0;
        check("pop_while_full_ready", in_ready, 1);
        repeat (3) step();
        for (int i = 1; i < DOTS; i++) tick(1'b0, 1'b0);
        line(-1); line(-1); line(-1);
        check("no_underflow_yet", underflow, 0);
        base = log_c.size();
        line(-1);
        check("underflow_set", underflow, 1);
        lit = '{9, 9, 9, 9, 9, 9, 9, 9};
        check_log("underflow_bg0", base, 1'b0);
        dot_tick = 1'b1; line_start = 1'b1; clr_uf = 1'b1;
        step();
        dot_tick = 1'b0; line_start = 1'b0; clr_uf = 1'b0;
        check("set_beats_clear", underflow, 1);
        repeat (3) step();
        for (int i = 1; i < DOTS; i++) tick(1'b0, 1'b0);
        clr_uf = 1'b1; step(); clr_uf = 1'b0;
        check("clear_underflow", underflow, 0);

        // border on dot 2
        do_reset();
        bg0 = 4'd0; ec = 4'd14; mode = 2'd0;
        push(8'h00, {4'd1, 4'd0, 4'd0});
        base = log_c.size();
        line(2);
        lit = '{0, 0, 14, 0, 0, 0, 0, 0};
        check_log("border", base, 1'b0);

        // invalid mode
        do_reset();
        mode = 2'd2;
        push(8'hFF, {4'd5, 4'd5, 4'd5});
        base = log_c.size();
        line(-1);
        lit  = '{0, 0, 0, 0, 0, 0, 0, 0};
        litb = '{1, 1, 1, 1, 1, 1, 1, 1};
        check_log("mode2", base, 1'b1);

        // reset mid-word with a pixel in flight
        do_reset();
        mode = 2'd0; bg0 = 4'd0;
        push(8'hFF, {4'd3, 4'd0, 4'd0});
        push(8'hFF, {4'd3, 4'd0, 4'd0});
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("pre_rst_color", pixel_color, 3);
        dot_tick = 1'b1; step(); dot_tick = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_valid", pixel_valid, 0);
        check("midrst_color", pixel_color, 0);
        check("midrst_bg", is_bg, 1);
        check("midrst_ready", in_ready, 1);
        step();
        check("midrst_no_stale", pixel_valid, 0);
        line(-1);
        check("midrst_fifo_empty", underflow, 1);
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
